sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Two-client front end for sdram_ctrl. Arbitrates single-word read/write requests from port 0
//  (display scanout, read-mostly) and port 1 (GPU general R/W), and issues one request at a time
//  over the controller's valid/ready interface. Returns read data to the issuing port only.
//  At most one transaction is outstanding at a time.
// PARAMETERS
//  ADDR_W   22  request address width; bank/row/col packing as the controller expects
//  DATA_W   16  SDRAM data bus width
// PORTS
//  clk_i            in   1       system clock; all logic rising-edge
//  rst_ni           in   1       asynchronous active-low reset
//  pN_req_i         in   1       port N (N=0,1) request pending; held until pN_ack_o
//  pN_we_i          in   1       1=write, 0=read; valid with pN_req_i
//  pN_addr_i        in   ADDR_W  word address
//  pN_wdata_i       in   DATA_W  write data
//  pN_ack_o         out  1       1-cycle pulse: request latched; client may change inputs next cycle
//  pN_rvalid_o      out  1       1-cycle pulse: pN_rdata_o valid
//  pN_rdata_o       out  DATA_W  read data, registered
//  ctrl_enabled_i   in   1       controller init complete
//  ctrl_ready_i     in   1       controller data_ready
//  ctrl_r_valid_o   out  1       read request to controller
//  ctrl_w_valid_o   out  1       write request to controller
//  ctrl_addr_o      out  ADDR_W  held address to controller
//  ctrl_wdata_o     out  DATA_W  held write data to controller
//  ctrl_r_valid_i   in   1       controller read-data strobe
//  ctrl_rdata_i     in   DATA_W  controller read data
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE. All *_o = 0, including rdata and the hold registers.
//  Reset release mid-transaction: the in-flight request is abandoned; no ack or rvalid is emitted.
//  FSM, all outputs registered:
//   IDLE:  if ctrl_enabled_i && (p0_req_i||p1_req_i): select winner; latch we/addr/wdata/port into
//          hold regs; pulse winner's ack next cycle; drive ctrl_r_valid_o=!we or ctrl_w_valid_o=we
//          -> ISSUE. Otherwise outputs idle; no ack.
//   ISSUE: hold ctrl valid/addr/wdata stable until the cycle in which ctrl_ready_i=1 (handshake).
//          Then clear valids; write -> IDLE, read -> WAIT_RD.
//   WAIT_RD: on ctrl_r_valid_i, register ctrl_rdata_i into the held port's rdata; pulse its rvalid
//          next cycle -> IDLE. The other port's rvalid/rdata are unchanged.
//  Latency: req->ack 1 cycle. ack->ctrl valid 0 cycles (same edge). ctrl_r_valid_i->pN_rvalid_o 1 cycle.
//  Write done -> next grant: one cycle minimum (IDLE re-evaluates).
//  Both ctrl valids are never high together. ack is never issued while not IDLE.
//  ctrl_enabled_i falling while in ISSUE/WAIT_RD: hold state; no timeout.
//  pN_req_i dropped before ack: request ignored. No error.
//  Arbitration (default, fixed priority): port 0 wins every tie.
// CONFIGURATION
//  `SDRAM_ARB_RR_EN defined: round-robin. 1-bit last_grant register (reset 1, so port 0 wins
//   the first tie). On a tie the port != last_grant wins. A single requester always wins.
//  Undefined: fixed priority, port 0 first; no last_grant register.
// STRUCTURE
//  sdram_pkg: arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RD}; typedef arb_port_t (1 bit);
//   localparam ARB_PORTS=2.
//  No sub-module; the winner select is a small combinational function in the module.
// TESTING
//  1 Reset: hold rst_ni=0 for 3 cycles with p0_req_i=1 -> no ack, all ctrl outputs 0.
//  2 p1 write addr=0x00123, data=0xBEEF, ctrl_ready_i=1 -> p1_ack_o pulse; ctrl_w_valid_o 1 cycle
//    with addr/data matching; p1_rvalid_o never asserts.
//  3 p0 read addr=0x3FFFFF; ctrl_ready_i delayed 4 cycles; ctrl_r_valid_i with 0xA5A5 6 cycles later
//    -> ctrl_r_valid_o held high 5 cycles; p0_rvalid_o=1, p0_rdata_o=0xA5A5 one cycle later;
//    p1_rvalid_o stays 0.
//  4 p0 read and p1 write requested in the same cycle, fixed priority -> p0 served first,
//    p1 acked only after p0's rvalid.
//    With SDRAM_ARB_RR_EN and 4 back-to-back ties -> grants alternate 0,1,0,1.
//  5 ctrl_enabled_i=0 with both ports requesting for 10 cycles -> no ack; grant on the first
//    cycle after enable rises.
//  6 Assert rst_ni=0 during WAIT_RD, then pulse ctrl_r_valid_i -> no rvalid on either port;
//    FSM in IDLE.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types for the two-port SDRAM arbiter front end.
package sdram_pkg;

    localparam int ARB_PORTS = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RD
    } arb_state_e;

    typedef logic [$clog2(ARB_PORTS)-1:0] arb_port_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Two-client arbiter issuing one request at a time to sdram_ctrl.
// Define SDRAM_ARB_RR_EN for round-robin ties; default is fixed priority (port 0).
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_ack_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_ack_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    input  logic              ctrl_enabled_i,
    input  logic              ctrl_ready_i,
    output logic              ctrl_r_valid_o,
    output logic              ctrl_w_valid_o,
    output logic [ADDR_W-1:0] ctrl_addr_o,
    output logic [DATA_W-1:0] ctrl_wdata_o,
    input  logic              ctrl_r_valid_i,
    input  logic [DATA_W-1:0] ctrl_rdata_i
);

    arb_state_e        state;
    arb_port_t         hold_port;
    arb_port_t         win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef SDRAM_ARB_RR_EN
    arb_port_t last_grant;

    // On a tie the port that did not win last time goes first.
    function automatic arb_port_t pick(input logic r0, input logic r1,
                                       input arb_port_t last);
        if (r0 && r1)
            return ~last;
        return arb_port_t'(!r0);
    endfunction
`else
    function automatic arb_port_t pick(input logic r0);
        return arb_port_t'(!r0);
    endfunction
`endif

    always_comb begin
`ifdef SDRAM_ARB_RR_EN
        win = pick(p0_req_i, p1_req_i, last_grant);
`else
        win = pick(p0_req_i);
`endif
        sel_we    = (win != '0) ? p1_we_i    : p0_we_i;
        sel_addr  = (win != '0) ? p1_addr_i  : p0_addr_i;
        sel_wdata = (win != '0) ? p1_wdata_i : p0_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ARB_IDLE;
            hold_port      <= '0;
`ifdef SDRAM_ARB_RR_EN
            last_grant     <= '1;
`endif
            p0_ack_o       <= 1'b0;
            p1_ack_o       <= 1'b0;
            p0_rvalid_o    <= 1'b0;
            p1_rvalid_o    <= 1'b0;
            p0_rdata_o     <= '0;
            p1_rdata_o     <= '0;
            ctrl_r_valid_o <= 1'b0;
            ctrl_w_valid_o <= 1'b0;
            ctrl_addr_o    <= '0;
            ctrl_wdata_o   <= '0;
        end else begin
            p0_ack_o    <= 1'b0;
            p1_ack_o    <= 1'b0;
            p0_rvalid_o <= 1'b0;
            p1_rvalid_o <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (ctrl_enabled_i && (p0_req_i || p1_req_i)) begin
                        hold_port      <= win;
`ifdef SDRAM_ARB_RR_EN
                        last_grant     <= win;
`endif
                        p0_ack_o       <= (win == '0);
                        p1_ack_o       <= (win != '0);
                        ctrl_addr_o    <= sel_addr;
                        ctrl_wdata_o   <= sel_wdata;
                        ctrl_r_valid_o <= !sel_we;
                        ctrl_w_valid_o <= sel_we;
                        state          <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (ctrl_ready_i) begin
                        ctrl_r_valid_o <= 1'b0;
                        ctrl_w_valid_o <= 1'b0;
                        state <= ctrl_w_valid_o ? ARB_IDLE : ARB_WAIT_RD;
                    end
                end
                ARB_WAIT_RD: begin
                    if (ctrl_r_valid_i) begin
                        if (hold_port == '0) begin
                            p0_rdata_o  <= ctrl_rdata_i;
                            p0_rvalid_o <= 1'b1;
                        end else begin
                            p1_rdata_o  <= ctrl_rdata_i;
                            p1_rvalid_o <= 1'b1;
                        end
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p0_ack, p0_rvalid;
    logic [21:0] p0_addr;
    logic [15:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_ack, p1_rvalid;
    logic [21:0] p1_addr;
    logic [15:0] p1_wdata, p1_rdata;
    logic        en, rdy, r_valid_o, w_valid_o, r_valid_i;
    logic [21:0] c_addr;
    logic [15:0] c_wdata, c_rdata;

    int   total = 0;
    int   bad = 0;
    logic exp_last;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr),
        .p0_wdata_i(p0_wdata), .p0_ack_o(p0_ack), .p0_rvalid_o(p0_rvalid),
        .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr),
        .p1_wdata_i(p1_wdata), .p1_ack_o(p1_ack), .p1_rvalid_o(p1_rvalid),
        .p1_rdata_o(p1_rdata),
        .ctrl_enabled_i(en), .ctrl_ready_i(rdy),
        .ctrl_r_valid_o(r_valid_o), .ctrl_w_valid_o(w_valid_o),
        .ctrl_addr_o(c_addr), .ctrl_wdata_o(c_wdata),
        .ctrl_r_valid_i(r_valid_i), .ctrl_rdata_i(c_rdata)
    );

    // Expected winner of a tie under the active arbitration scheme.
    function automatic logic tie_winner();
`ifdef SDRAM_ARB_RR_EN
        return ~exp_last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        rdy = 0; r_valid_i = 0; c_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        exp_last = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0; en = 1; rdy = 1;
        p0_req = 1; p0_addr = 22'h5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({p0_ack, p1_ack, r_valid_o, w_valid_o} !== 4'b0) begin
                bad++;
                $display("FAIL reset_c%0d: ack0/ack1/rv/wv=%b want 0000",
                         i, {p0_ack, p1_ack, r_valid_o, w_valid_o});
            end
        end
        total++;
        if ({c_addr, c_wdata, p0_rdata, p1_rdata, p0_rvalid, p1_rvalid} !== '0) begin
            bad++;
            $display("FAIL reset_regs: addr=%h wdata=%h rd0=%h rd1=%h want 0",
                     c_addr, c_wdata, p0_rdata, p1_rdata);
        end
        p0_req = 0;
        rdy = 0;
        @(negedge clk);
        rst_n = 1;
        exp_last = 1'b1;
    endtask

    task automatic test_write();
        logic seen_rv = 0;
        @(negedge clk);
        p1_req = 1; p1_we = 1; p1_addr = 22'h00123; p1_wdata = 16'hBEEF;
        rdy = 1;
        @(negedge clk);
        total++;
        if ({p0_ack, p1_ack, r_valid_o, w_valid_o, c_addr, c_wdata} !==
            {1'b0, 1'b1, 1'b0, 1'b1, 22'h00123, 16'hBEEF}) begin
            bad++;
            $display("FAIL wr_grant: ack0=%b ack1=%b rv=%b wv=%b addr=%h wd=%h want 0 1 0 1 000123 beef",
                     p0_ack, p1_ack, r_valid_o, w_valid_o, c_addr, c_wdata);
        end
        exp_last = 1'b1;
        p1_req = 0;
        @(negedge clk);
        total++;
        if ({p1_ack, w_valid_o} !== 2'b00) begin
            bad++;
            $display("FAIL wr_one_cycle: ack1=%b wv=%b want 0 0", p1_ack, w_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (p1_rvalid) seen_rv = 1;
            @(negedge clk);
        end
        total++;
        if (seen_rv !== 1'b0) begin
            bad++;
            $display("FAIL wr_no_rvalid: p1_rvalid seen=%b want 0", seen_rv);
        end
        rdy = 0;
    endtask

    task automatic test_read_delayed();
        int   hi = 0;
        logic early = 0;
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 22'h3FFFFF;
        rdy = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total++;
                if ({p0_ack, p1_ack} !== 2'b10) begin
                    bad++;
                    $display("FAIL rd_ack: ack0=%b ack1=%b want 1 0", p0_ack, p1_ack);
                end
                p0_req = 0;
            end
            if (r_valid_o === 1'b1 && w_valid_o === 1'b0 && c_addr === 22'h3FFFFF)
                hi++;
            if (i == 5) rdy = 1;
        end
        total++;
        if (hi != 5) begin
            bad++;
            $display("FAIL rd_valid_hold: cycles=%0d want 5", hi);
        end
        exp_last = 1'b0;
        @(negedge clk);
        rdy = 0;
        total++;
        if (r_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_valid_clear: rv=%b want 0", r_valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            if (p0_rvalid || p1_rvalid) early = 1;
            @(negedge clk);
        end
        if (p0_rvalid || p1_rvalid) early = 1;
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL rd_early_rvalid: seen=%b want 0", early);
        end
        r_valid_i = 1; c_rdata = 16'hA5A5;
        @(negedge clk);
        r_valid_i = 0; c_rdata = 16'h0000;
        total++;
        if ({p0_rvalid, p0_rdata, p1_rvalid} !== {1'b1, 16'hA5A5, 1'b0}) begin
            bad++;
            $display("FAIL rd_data: rv0=%b rd0=%h rv1=%b want 1 a5a5 0",
                     p0_rvalid, p0_rdata, p1_rvalid);
        end
        @(negedge clk);
        total++;
        if ({p0_rvalid, p0_rdata, p1_rvalid, p1_rdata} !==
            {1'b0, 16'hA5A5, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL rd_pulse: rv0=%b rd0=%h rv1=%b rd1=%h want 0 a5a5 0 0000",
                     p0_rvalid, p0_rdata, p1_rvalid, p1_rdata);
        end
    endtask

    task automatic test_priority();
        logic early = 0;
        do_reset();
        p0_req = 1; p0_we = 0; p0_addr = 22'h10;
        p1_req = 1; p1_we = 1; p1_addr = 22'h20; p1_wdata = 16'h1234;
        rdy = 1;
        @(negedge clk);
        total++;
        if ({p0_ack, p1_ack, r_valid_o, w_valid_o, c_addr} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 22'h10}) begin
            bad++;
            $display("FAIL prio_first: ack0=%b ack1=%b rv=%b wv=%b addr=%h want 1 0 1 0 000010",
                     p0_ack, p1_ack, r_valid_o, w_valid_o, c_addr);
        end
        exp_last = 1'b0;
        p0_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (p1_ack) early = 1;
        end
        r_valid_i = 1; c_rdata = 16'h5555;
        @(negedge clk);
        r_valid_i = 0;
        if (p1_ack) early = 1;
        total++;
        if ({p0_rvalid, p0_rdata, early} !== {1'b1, 16'h5555, 1'b0}) begin
            bad++;
            $display("FAIL prio_rd: rv0=%b rd0=%h early_ack1=%b want 1 5555 0",
                     p0_rvalid, p0_rdata, early);
        end
        @(negedge clk);
        total++;
        if ({p1_ack, w_valid_o, c_addr, c_wdata} !==
            {1'b1, 1'b1, 22'h20, 16'h1234}) begin
            bad++;
            $display("FAIL prio_second: ack1=%b wv=%b addr=%h wd=%h want 1 1 000020 1234",
                     p1_ack, w_valid_o, c_addr, c_wdata);
        end
        exp_last = 1'b1;
        p1_req = 0;
        @(negedge clk);
        total++;
        if (w_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL prio_wdone: wv=%b want 0", w_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic w;
        logic got;
        logic gport;
        logic [21:0] waddr;
        rdy = 1;
        p0_req = 1; p0_we = 1; p0_addr = 22'h100; p0_wdata = 16'h0A00;
        p1_req = 1; p1_we = 1; p1_addr = 22'h200; p1_wdata = 16'h0B00;
        for (int k = 0; k < 4; k++) begin
            w = tie_winner();
            waddr = w ? p1_addr : p0_addr;
            got = 0; gport = 0;
            for (int c = 0; c < 4 && !got; c++) begin
                @(negedge clk);
                if (p0_ack || p1_ack) begin
                    got = 1;
                    gport = p1_ack;
                end
            end
            total++;
            if (!got || gport !== w || (p0_ack && p1_ack) || c_addr !== waddr) begin
                bad++;
                $display("FAIL b2b_grant%0d: got=%b port=%b addr=%h want 1 %b %h",
                         k, got, gport, c_addr, w, waddr);
            end
            exp_last = w;
            if (w) p1_addr = p1_addr + 1;
            else   p0_addr = p0_addr + 1;
        end
        p0_req = 0; p1_req = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_enable();
        logic w;
        rdy = 1;
        @(negedge clk);
        en = 0;
        p0_req = 1; p0_we = 1; p0_addr = 22'h300;
        p1_req = 1; p1_we = 1; p1_addr = 22'h301;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({p0_ack, p1_ack, w_valid_o, r_valid_o} !== 4'b0) begin
                bad++;
                $display("FAIL en_low_c%0d: ack0/ack1/wv/rv=%b want 0000",
                         i, {p0_ack, p1_ack, w_valid_o, r_valid_o});
            end
        end
        en = 1;
        w = tie_winner();
        @(negedge clk);
        total++;
        if ({p0_ack, p1_ack} !== {!w, w}) begin
            bad++;
            $display("FAIL en_rise: ack0=%b ack1=%b want %b %b", p0_ack, p1_ack, !w, w);
        end
        exp_last = w;
        p0_req = 0; p1_req = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen = 0;
        rdy = 1;
        p0_req = 1; p0_we = 0; p0_addr = 22'h55;
        @(negedge clk);
        total++;
        if (p0_ack !== 1'b1) begin
            bad++;
            $display("FAIL mid_ack: ack0=%b want 1", p0_ack);
        end
        p0_req = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        total++;
        if ({p0_ack, p1_ack, r_valid_o, w_valid_o, c_addr, p0_rdata} !== '0) begin
            bad++;
            $display("FAIL mid_async: ack0=%b ack1=%b rv=%b wv=%b addr=%h rd0=%h want all 0",
                     p0_ack, p1_ack, r_valid_o, w_valid_o, c_addr, p0_rdata);
        end
        r_valid_i = 1; c_rdata = 16'h7777;
        @(negedge clk);
        rst_n = 1;
        exp_last = 1'b1;
        @(negedge clk);
        r_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (p0_rvalid || p1_rvalid || p0_rdata != 16'h0) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_rvalid: seen=%b want 0", seen);
        end
        p1_req = 1; p1_we = 1; p1_addr = 22'h66; p1_wdata = 16'h0066;
        @(negedge clk);
        total++;
        if ({p1_ack, w_valid_o} !== 2'b11) begin
            bad++;
            $display("FAIL mid_idle: ack1=%b wv=%b want 1 1", p1_ack, w_valid_o);
        end
        p1_req = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        en = 1;
        rst_n = 0;
        exp_last = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read_delayed();
        test_priority();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
